// File: rtl/rv_iommu_wsi_gen.sv
// Wired-signalled interrupt generator for the RISC-V IOMMU: latches pending
// sources, routes them through per-source vector indices, drives WSI wires.
module rv_iommu_wsi_gen #(
  parameter int N_SRC        = 4,
  parameter int N_INT_VEC    = 16,
  parameter int IVEC_W       = (N_INT_VEC > 1) ? $clog2(N_INT_VEC) : 1,
  parameter int PULSE_MODE   = 0,
  parameter int PULSE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_SRC-1:0]        src_evt_i,
  input  logic [N_SRC-1:0]        src_ie_i,
  input  logic [N_SRC*IVEC_W-1:0] ivec_i,
  input  logic [N_SRC-1:0]        ipsr_clr_i,
  input  logic                    wsi_en_i,
  output logic [N_SRC-1:0]        ipsr_o,
  output logic [N_INT_VEC-1:0]    wsi_wires_o
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } wsi_state_e;

  logic [N_SRC-1:0]     ipsr_r;
  logic [N_INT_VEC-1:0] req_s;

  // Pending latch: a new event outranks a simultaneous W1C clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ipsr_r <= '0;
    end else begin
      ipsr_r <= src_evt_i | (ipsr_r & ~ipsr_clr_i);
    end
  end

  assign ipsr_o = ipsr_r;

  // Routing: out-of-range indices never equal a valid wire number, so they drop out.
  always_comb begin
    req_s = '0;
    for (int w = 0; w < N_INT_VEC; w++) begin
      for (int s = 0; s < N_SRC; s++) begin
        req_s[w] = req_s[w] |
                   (ipsr_r[s] & src_ie_i[s] & (ivec_i[s*IVEC_W +: IVEC_W] == IVEC_W'(w)));
      end
    end
  end

  for (genvar w = 0; w < N_INT_VEC; w++) begin : g_wire
    logic wire_r;

    if (PULSE_MODE != 0) begin : g_pulse
      wsi_state_e       state_r;
      logic [CNT_W-1:0] cnt_r;

      // Per-wire pulse FSM; disabling WSI aborts any pulse and re-arms the wire.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          wire_r  <= 1'b0;
        end else if (!wsi_en_i) begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          wire_r  <= 1'b0;
        end else begin
          case (state_r)
            ST_IDLE: begin
              if (req_s[w]) begin
                state_r <= ST_PULSE;
                cnt_r   <= CNT_W'(PULSE_CYCLES - 1);
                wire_r  <= 1'b1;
              end else begin
                state_r <= ST_IDLE;
                wire_r  <= 1'b0;
              end
            end
            ST_PULSE: begin
              if (cnt_r == '0) begin
                state_r <= ST_WAIT;
                wire_r  <= 1'b0;
              end else begin
                cnt_r  <= cnt_r - CNT_W'(1);
                wire_r <= 1'b1;
              end
            end
            ST_WAIT: begin
              wire_r <= 1'b0;
              if (!req_s[w]) begin
                state_r <= ST_IDLE;
              end else begin
                state_r <= ST_WAIT;
              end
            end
            default: begin
              state_r <= ST_IDLE;
              cnt_r   <= '0;
              wire_r  <= 1'b0;
            end
          endcase
        end
      end
    end else begin : g_level
      // Level wire follows the gated request one edge later.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          wire_r <= 1'b0;
        end else begin
          wire_r <= req_s[w] & wsi_en_i;
        end
      end
    end

    assign wsi_wires_o[w] = wire_r;
  end

endmodule

// File: tb/tb_rv_iommu_wsi_gen.sv
// Directed bench for rv_iommu_wsi_gen: three instances (level/16, level/12,
// pulse/16) share stimulus and are checked every cycle against a reference model.
module tb_rv_iommu_wsi_gen;

  localparam int PC = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_evt;
  logic [3:0]  src_ie;
  logic [15:0] ivec;
  logic [3:0]  ipsr_clr;
  logic        wsi_en;

  logic [3:0]  ipsr_l16, ipsr_l12, ipsr_p;
  logic [15:0] wires_l16, wires_p;
  logic [11:0] wires_l12;

  int n_tests = 0;
  int n_fail  = 0;

  rv_iommu_wsi_gen #(.N_SRC(4), .N_INT_VEC(16), .PULSE_MODE(0)) u_lvl16 (
    .clk_i(clk), .rst_ni(rst_n), .src_evt_i(src_evt), .src_ie_i(src_ie), .ivec_i(ivec),
    .ipsr_clr_i(ipsr_clr), .wsi_en_i(wsi_en), .ipsr_o(ipsr_l16), .wsi_wires_o(wires_l16));

  rv_iommu_wsi_gen #(.N_SRC(4), .N_INT_VEC(12), .PULSE_MODE(0)) u_lvl12 (
    .clk_i(clk), .rst_ni(rst_n), .src_evt_i(src_evt), .src_ie_i(src_ie), .ivec_i(ivec),
    .ipsr_clr_i(ipsr_clr), .wsi_en_i(wsi_en), .ipsr_o(ipsr_l12), .wsi_wires_o(wires_l12));

  rv_iommu_wsi_gen #(.N_SRC(4), .N_INT_VEC(16), .PULSE_MODE(1), .PULSE_CYCLES(PC)) u_pls (
    .clk_i(clk), .rst_ni(rst_n), .src_evt_i(src_evt), .src_ie_i(src_ie), .ivec_i(ivec),
    .ipsr_clr_i(ipsr_clr), .wsi_en_i(wsi_en), .ipsr_o(ipsr_p), .wsi_wires_o(wires_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which wires are requested, given pending bits, enables and vector table.
  function automatic logic [15:0] route(input logic [3:0] ip, input logic [3:0] ie,
                                        input logic [15:0] iv, input int n);
    logic [15:0] r;
    r = 16'h0000;
    for (int s = 0; s < 4; s++) begin
      if (ip[s] && ie[s] && (int'(iv[s*4 +: 4]) < n)) r[iv[s*4 +: 4]] = 1'b1;
    end
    return r;
  endfunction

  // Reference model state
  logic [3:0]  m_ipsr;
  logic [15:0] m_l16, m_p;
  logic [11:0] m_l12;
  int          p_left [16];   // high cycles still owed on this wire, including the current one
  bit          p_armed[16];   // wire may start a new pulse once its request is seen
  logic [15:0] m_req16, m_req12;

  assign m_req16 = route(m_ipsr, src_ie, ivec, 16);
  assign m_req12 = route(m_ipsr, src_ie, ivec, 12);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ipsr <= 4'h0;
      m_l16  <= 16'h0000;
      m_l12  <= 12'h000;
      m_p    <= 16'h0000;
      for (int w = 0; w < 16; w++) begin
        p_left[w]  <= 0;
        p_armed[w] <= 1'b1;
      end
    end else begin
      m_ipsr <= src_evt | (m_ipsr & ~ipsr_clr);
      m_l16  <= wsi_en ? m_req16 : 16'h0000;
      m_l12  <= wsi_en ? m_req12[11:0] : 12'h000;
      for (int w = 0; w < 16; w++) begin
        if (!wsi_en) begin
          p_left[w] <= 0; p_armed[w] <= 1'b1; m_p[w] <= 1'b0;
        end else if (p_left[w] > 1) begin
          p_left[w] <= p_left[w] - 1; m_p[w] <= 1'b1;
        end else if (p_left[w] == 1) begin
          p_left[w] <= 0; p_armed[w] <= 1'b0; m_p[w] <= 1'b0;
        end else if (!p_armed[w]) begin
          p_armed[w] <= !m_req16[w]; m_p[w] <= 1'b0;
        end else if (m_req16[w]) begin
          p_left[w] <= PC; m_p[w] <= 1'b1;
        end else begin
          m_p[w] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ipsr_l16", 32'(ipsr_l16), 32'(m_ipsr));
    chk("ipsr_l12", 32'(ipsr_l12), 32'(m_ipsr));
    chk("ipsr_pls", 32'(ipsr_p), 32'(m_ipsr));
    chk("wires_l16", 32'(wires_l16), 32'(m_l16));
    chk("wires_l12", 32'(wires_l12), 32'(m_l12));
    chk("wires_pls", 32'(wires_p), 32'(m_p));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_high(input int n, output int hi, output int rises);
    logic prev;
    prev  = wires_p[7];
    hi    = 0;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (wires_p[7]) hi++;
      if (wires_p[7] && !prev) rises++;
      prev = wires_p[7];
    end
  endtask

  int hi, rises;

  initial begin
    rst_n = 1'b1; src_evt = 4'h0; src_ie = 4'h0; ivec = 16'h0000;
    ipsr_clr = 4'h0; wsi_en = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_ipsr", 32'(ipsr_l16), 32'h0);
    chk("reset_wires", 32'(wires_l16 | wires_p), 32'h0);
    rst_n = 1'b1;
    tick();

    // Level basic: source 0 -> wire 3
    ivec[3:0] = 4'd3; src_ie = 4'b0001;
    src_evt = 4'b0001; tick(); src_evt = 4'h0;
    chk("basic_ipsr", 32'(ipsr_l16), 32'h1);
    chk("basic_wire_latency", 32'(wires_l16), 32'h0);
    tick();
    chk("basic_wire", 32'(wires_l16), 32'h0008);
    ipsr_clr = 4'b0001; tick(); ipsr_clr = 4'h0;
    chk("clr_ipsr", 32'(ipsr_l16), 32'h0);
    chk("clr_wire_hold", 32'(wires_l16), 32'h0008);
    tick();
    chk("clr_wire_drop", 32'(wires_l16), 32'h0);

    // Set/clear collision on source 1
    ivec[7:4] = 4'd1; src_ie = 4'b0010;
    src_evt = 4'b0010; tick(); src_evt = 4'h0; tick();
    src_evt = 4'b0010; ipsr_clr = 4'b0010; tick();
    chk("collide_set_wins", 32'(ipsr_l16), 32'h2);
    src_evt = 4'h0; tick(); ipsr_clr = 4'h0;
    chk("clear_alone", 32'(ipsr_l16), 32'h0);
    tick();

    // Shared wire 5 from sources 0 and 2
    ivec[3:0] = 4'd5; ivec[11:8] = 4'd5; src_ie = 4'b0101;
    src_evt = 4'b0101; tick(); src_evt = 4'h0; tick();
    chk("shared_both", 32'(wires_l16), 32'h0020);
    ipsr_clr = 4'b0001; tick(); ipsr_clr = 4'h0; tick();
    chk("shared_one_left", 32'(wires_l16), 32'h0020);
    ipsr_clr = 4'b0100; tick(); ipsr_clr = 4'h0; tick();
    chk("shared_none", 32'(wires_l16), 32'h0);

    // Out-of-range index 15 on the 12-wire instance
    ivec[7:4] = 4'd15; src_ie = 4'b0010;
    src_evt = 4'b0010; tick(); src_evt = 4'h0; tick();
    chk("oor_l16", 32'(wires_l16), 32'h8000);
    chk("oor_l12", 32'(wires_l12), 32'h0);
    ipsr_clr = 4'b0010; tick(); ipsr_clr = 4'h0; tick(); tick();

    // Pulse: source 3 -> wire 7, held pending for 24 cycles
    ivec[15:12] = 4'd7; src_ie = 4'b1000;
    src_evt = 4'b1000; tick(); src_evt = 4'h0;
    chk("pulse_latency", 32'(wires_p), 32'h0);
    count_high(24, hi, rises);
    chk("pulse_width", 32'(hi), 32'd4);
    chk("pulse_no_repeat", 32'(rises), 32'd1);
    ipsr_clr = 4'b1000; tick(); ipsr_clr = 4'h0; tick();
    src_evt = 4'b1000; tick(); src_evt = 4'h0;
    count_high(10, hi, rises);
    chk("repulse_width", 32'(hi), 32'd4);
    chk("repulse_count", 32'(rises), 32'd1);

    // Enable gating with source 3 pending
    wsi_en = 1'b0; tick();
    chk("gate_lvl", 32'(wires_l16), 32'h0);
    chk("gate_pls", 32'(wires_p), 32'h0);
    chk("gate_ipsr_kept", 32'(ipsr_l16), 32'h8);
    wsi_en = 1'b1; tick();
    chk("reen_lvl", 32'(wires_l16), 32'h0080);
    chk("reen_pls", 32'(wires_p), 32'h0080);
    tick();
    wsi_en = 1'b0; tick();
    chk("abort_pls", 32'(wires_p), 32'h0);
    wsi_en = 1'b1;
    count_high(8, hi, rises);
    chk("fresh_pulse_width", 32'(hi), 32'd4);

    // Asynchronous reset in the middle of a pulse
    wsi_en = 1'b0; tick(); wsi_en = 1'b1; tick();
    chk("pre_reset_pls", 32'(wires_p), 32'h0080);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pls", 32'(wires_p), 32'h0);
    chk("async_rst_lvl", 32'(wires_l16), 32'h0);
    chk("async_rst_ipsr", 32'(ipsr_p), 32'h0);
    #3 rst_n = 1'b1;
    count_high(6, hi, rises);
    chk("post_reset_idle", 32'(hi), 32'd0);
    chk("post_reset_ipsr", 32'(ipsr_p), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
